// File: rtl/sipo_rx_controller_pkg.sv
// sipo_pkg: shared state encoding and frame line levels for the SIPO receive controller.
//   state_t   : IDLE / DATA / PARITY / STOP FSM encoding
//   START_LVL : sdi level that opens a frame
//   STOP_LVL  : sdi level a well-formed frame must end with
package sipo_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;
    localparam logic START_LVL = 1'b1;
    localparam logic STOP_LVL  = 1'b0;
endpackage

// File: rtl/sipo_rx_controller_if.sv
// sipo_rx_if: serial-in / parallel-out bus between the serial pin, the controller and the consumer.
//   sdi, data_ready, ovr_clr                                   : into the controller
//   data_out, data_valid, parity_err, framing_err, overrun, busy : out of the controller
//   slave modport = controller side, master modport = pin/consumer side
interface sipo_rx_if #(parameter int WIDTH = 4);
    logic             sdi;
    logic             data_ready;
    logic             ovr_clr;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             parity_err;
    logic             framing_err;
    logic             overrun;
    logic             busy;
    modport slave (
        input  sdi, data_ready, ovr_clr,
        output data_out, data_valid, parity_err, framing_err, overrun, busy
    );
    modport master (
        output sdi, data_ready, ovr_clr,
        input  data_out, data_valid, parity_err, framing_err, overrun, busy
    );
endinterface

// File: rtl/sipo_rx_controller_shift_reg.sv
// shift_reg_sipo_n: WIDTH-bit serial-in/parallel-out shift register, first bit ends at MSB.
//   clk   : rising-edge clock
//   reset : asynchronous active-high clear
//   en    : shift enable
//   sdi   : serial input, enters at LSB
//   q     : parallel contents
module shift_reg_sipo_n #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             sdi,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            q <= '0;
        else if (en)
            q <= {q[WIDTH-2:0], sdi};
    end
endmodule

// File: rtl/sipo_rx_controller.sv
// sipo_rx_controller: frames a serial stream into WIDTH-bit words with optional even parity and a valid/ready output.
//   clk   : rising-edge clock, sdi sampled once per edge
//   reset : asynchronous active-high reset
//   bus   : sipo_rx_if.slave
//     in  sdi, data_ready, ovr_clr
//     out data_out (first bit at MSB), data_valid, parity_err / framing_err (1-cycle pulses),
//         overrun (sticky), busy (not IDLE)
module sipo_rx_controller
    import sipo_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic     clk,
    input  logic     reset,
    sipo_rx_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_perr;
    logic [WIDTH-1:0] r_data_out;
    logic             r_data_valid;
    logic             r_parity_err;
    logic             r_framing_err;
    logic             r_overrun;
    logic [WIDTH-1:0] w_sr;
    logic             w_accept;

    assign w_accept = r_data_valid & bus.data_ready;

    shift_reg_sipo_n #(.WIDTH(WIDTH)) u_sr (
        .clk   (clk),
        .reset (reset),
        .en    (r_state == DATA),
        .sdi   (bus.sdi),
        .q     (w_sr)
    );

    // Later assignments in the case override the accept/clear defaults:
    // a load beats an accept, an overrun set beats ovr_clr.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_perr        <= 1'b0;
            r_data_out    <= '0;
            r_data_valid  <= 1'b0;
            r_parity_err  <= 1'b0;
            r_framing_err <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_parity_err  <= 1'b0;
            r_framing_err <= 1'b0;
            if (w_accept)
                r_data_valid <= 1'b0;
            if (bus.ovr_clr)
                r_overrun <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.sdi == START_LVL) begin
                        r_state <= DATA;
                        r_cnt   <= '0;
                        r_perr  <= 1'b0;
                    end
                end
                DATA: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_cnt   <= '0;
                        r_state <= PARITY_EN ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    r_perr  <= (^w_sr) != bus.sdi;
                    r_state <= STOP;
                end
                STOP: begin
                    r_state <= IDLE;
                    if (bus.sdi != STOP_LVL)
                        r_framing_err <= 1'b1;
                    else if (r_perr)
                        r_parity_err <= 1'b1;
                    else if (!r_data_valid || bus.data_ready) begin
                        r_data_out   <= w_sr;
                        r_data_valid <= 1'b1;
                    end else
                        r_overrun <= 1'b1;
                end
            endcase
        end
    end

    assign bus.data_out    = r_data_out;
    assign bus.data_valid  = r_data_valid;
    assign bus.parity_err  = r_parity_err;
    assign bus.framing_err = r_framing_err;
    assign bus.overrun     = r_overrun;
    assign bus.busy        = r_state != IDLE;
endmodule

// File: tb/tb_sipo_rx_controller.sv
// tb_sipo_rx_controller: directed bench with a scoreboard of expected words popped on each accept.
module tb_sipo_rx_controller;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   passed = 0;
    logic [3:0] exp_q[$];

    sipo_rx_if #(.WIDTH(4)) bus ();

    sipo_rx_controller #(.WIDTH(4), .PARITY_EN(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic shift_bit(input logic b);
        bus.sdi = b;
        tick();
    endtask

    task automatic send_frame(input logic [3:0] d, input logic p, input logic s);
        shift_bit(1'b1);
        for (int i = 3; i >= 0; i--) shift_bit(d[i]);
        shift_bit(p);
        shift_bit(s);
    endtask

    // Every accepted word must be the oldest outstanding expected word.
    always @(negedge clk) begin
        if (!reset && bus.data_valid && bus.data_ready) begin
            if (exp_q.size() == 0)
                chk("unexpected_accept", 32'(bus.data_out), 32'hdead);
            else
                chk("sb_word", 32'(bus.data_out), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        reset = 1'b1;
        bus.sdi = 1'b0;
        bus.data_ready = 1'b0;
        bus.ovr_clr = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        // 1: idle after reset
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_busy", 32'(bus.busy), 0);
        end
        chk("rst_data_out", 32'(bus.data_out), 0);
        chk("rst_valid", 32'(bus.data_valid), 0);
        chk("rst_perr", 32'(bus.parity_err), 0);
        chk("rst_ferr", 32'(bus.framing_err), 0);
        chk("rst_ovr", 32'(bus.overrun), 0);
        // 2: good frame 1011, latency 7
        bus.data_ready = 1'b1;
        exp_q.push_back(4'b1011);
        shift_bit(1'b1);
        chk("busy_after_start", 32'(bus.busy), 1);
        shift_bit(1'b1); shift_bit(1'b0); shift_bit(1'b1); shift_bit(1'b1); shift_bit(1'b1);
        chk("valid_early", 32'(bus.data_valid), 0);
        shift_bit(1'b0);
        chk("valid_at_7", 32'(bus.data_valid), 1);
        chk("data_1011", 32'(bus.data_out), 32'b1011);
        chk("busy_after_stop", 32'(bus.busy), 0);
        tick();
        chk("valid_one_cycle", 32'(bus.data_valid), 0);
        // 3: parity error, then framing error
        send_frame(4'b1011, 1'b0, 1'b0);
        chk("perr_pulse", 32'(bus.parity_err), 1);
        chk("perr_no_valid", 32'(bus.data_valid), 0);
        chk("perr_no_ferr", 32'(bus.framing_err), 0);
        tick();
        chk("perr_clear", 32'(bus.parity_err), 0);
        send_frame(4'b1011, 1'b1, 1'b1);
        bus.sdi = 1'b0;
        chk("ferr_pulse", 32'(bus.framing_err), 1);
        chk("ferr_no_valid", 32'(bus.data_valid), 0);
        chk("ferr_keeps_data", 32'(bus.data_out), 32'b1011);
        tick();
        chk("ferr_clear", 32'(bus.framing_err), 0);
        chk("ferr_idle", 32'(bus.busy), 0);
        // 4: overrun with consumer stalled
        bus.data_ready = 1'b0;
        exp_q.push_back(4'b0101);
        send_frame(4'b0101, 1'b0, 1'b0);
        chk("ovr_first_ok", 32'(bus.overrun), 0);
        send_frame(4'b0011, 1'b0, 1'b0);
        chk("ovr_set", 32'(bus.overrun), 1);
        chk("ovr_held_data", 32'(bus.data_out), 32'b0101);
        chk("ovr_valid", 32'(bus.data_valid), 1);
        bus.ovr_clr = 1'b1;
        tick();
        bus.ovr_clr = 1'b0;
        chk("ovr_cleared", 32'(bus.overrun), 0);
        chk("ovr_clr_valid", 32'(bus.data_valid), 1);
        // 5: accept and load on the same STOP edge
        exp_q.push_back(4'b1110);
        shift_bit(1'b1);
        shift_bit(1'b1); shift_bit(1'b1); shift_bit(1'b1); shift_bit(1'b0);
        shift_bit(1'b1);
        bus.data_ready = 1'b1;
        shift_bit(1'b0);
        chk("swap_valid", 32'(bus.data_valid), 1);
        chk("swap_data", 32'(bus.data_out), 32'b1110);
        chk("swap_no_ovr", 32'(bus.overrun), 0);
        tick();
        chk("swap_drained", 32'(bus.data_valid), 0);
        // 6: reset mid-DATA, then a clean frame
        shift_bit(1'b1); shift_bit(1'b1); shift_bit(1'b0);
        chk("mid_busy", 32'(bus.busy), 1);
        reset = 1'b1;
        #1;
        chk("async_busy", 32'(bus.busy), 0);
        chk("async_data", 32'(bus.data_out), 0);
        bus.sdi = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        chk("post_rst_idle", 32'(bus.busy), 0);
        exp_q.push_back(4'b1001);
        send_frame(4'b1001, 1'b0, 1'b0);
        chk("post_rst_valid", 32'(bus.data_valid), 1);
        chk("post_rst_data", 32'(bus.data_out), 32'b1001);
        tick();
        tick();
        chk("sb_empty", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
